// File: rtl/sram_port_ctrl.sv
`timescale 1ns / 1ps
// Single-port SRAM front end: arbitrates write and read-request channels onto one access per
// cycle and captures the macro's registered Q into a 2-entry response FIFO.
module sram_port_ctrl #(
    parameter int DATA_W = 80,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,

    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    input  logic [ADDR_W-1:0] rd_req_addr,

    output logic              rd_resp_valid,
    input  logic              rd_resp_ready,
    output logic [DATA_W-1:0] rd_resp_data,

    output logic              sram_CEB,
    output logic              sram_WEB,
    output logic [ADDR_W-1:0] sram_A,
    output logic [DATA_W-1:0] sram_D,
    input  logic [DATA_W-1:0] sram_Q
);

    logic              inflight;
    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              last_conflict_wr;
    logic [DATA_W-1:0] fifo_mem [2];

    logic       deq;
    logic       rd_ok;
    logic       conflict;
    logic       grant_wr;
    logic       grant_rd;
    logic [2:0] occupancy;

    // Occupancy counts the in-flight read so the FIFO can never be oversubscribed.
    always_comb begin
        rd_resp_valid = (count != 2'd0);
        deq           = rd_resp_valid & rd_resp_ready;
        occupancy     = {1'b0, count} + {2'b00, inflight} - {2'b00, deq};
        rd_ok         = rd_req_valid & (occupancy < 3'd2);
        conflict      = wr_valid & rd_ok;
        grant_wr      = wr_valid & (~rd_ok | ~last_conflict_wr);
        grant_rd      = rd_ok & ~grant_wr;
        wr_ready      = grant_wr;
        rd_req_ready  = grant_rd;
        rd_resp_data  = fifo_mem[rd_ptr];
    end

    always_comb begin
        sram_CEB = 1'b1;
        sram_WEB = 1'b1;
        sram_A   = '0;
        sram_D   = '0;
        if (grant_wr) begin
            sram_CEB = 1'b0;
            sram_WEB = 1'b0;
            sram_A   = wr_addr;
            sram_D   = wr_data;
        end else if (grant_rd) begin
            sram_CEB = 1'b0;
            sram_A   = rd_req_addr;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight         <= 1'b0;
            count            <= 2'd0;
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            last_conflict_wr <= 1'b0;
            fifo_mem[0]      <= '0;
            fifo_mem[1]      <= '0;
        end else begin
            inflight <= grant_rd;
            if (conflict) begin
                last_conflict_wr <= grant_wr;
            end
            // Q is only meaningful the cycle after a read issue.
            if (inflight) begin
                fifo_mem[wr_ptr] <= sram_Q;
                wr_ptr           <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({inflight, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    fifo_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(inflight && (count == 2'd2) && !deq));

    addr_in_range: assert property (@(posedge clock) disable iff (reset)
        !sram_CEB |-> (int'(sram_A) < DEPTH));

endmodule

// File: tb/tb_sram_port_ctrl.sv
`timescale 1ns / 1ps
// Directed bench for sram_port_ctrl with a behavioural SRAM macro and a response scoreboard.
module tb_sram_port_ctrl;

    localparam int DW = 80;
    localparam int AW = 6;

    logic          clock;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req_valid;
    logic          rd_req_ready;
    logic [AW-1:0] rd_req_addr;
    logic          rd_resp_valid;
    logic          rd_resp_ready;
    logic [DW-1:0] rd_resp_data;
    logic          sram_CEB;
    logic          sram_WEB;
    logic [AW-1:0] sram_A;
    logic [DW-1:0] sram_D;
    logic [DW-1:0] sram_Q;

    logic [DW-1:0] sram_mem [64];
    logic [DW-1:0] exp_q [$];
    int            resp_cycles [$];
    logic [DW-1:0] exp_rd_data;
    logic [DW-1:0] t4_d [6];
    int            cyc = 0;
    int            checks = 0;
    int            passes = 0;
    int            grant_cyc;
    int            idx;

    sram_port_ctrl #(.DATA_W(DW), .DEPTH(64), .ADDR_W(AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_resp_valid(rd_resp_valid),
        .rd_resp_ready(rd_resp_ready),
        .rd_resp_data (rd_resp_data),
        .sram_CEB     (sram_CEB),
        .sram_WEB     (sram_WEB),
        .sram_A       (sram_A),
        .sram_D       (sram_D),
        .sram_Q       (sram_Q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] rnd80();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // Macro model: registered Q, garbage on every non-read cycle.
    always @(posedge clock) begin
        if (!sram_CEB && !sram_WEB) sram_mem[sram_A] <= sram_D;
        if (!sram_CEB && sram_WEB) sram_Q <= sram_mem[sram_A];
        else sram_Q <= rnd80();
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act,
                              input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor pops before the grant observer pushes, so same-edge ordering is fixed.
    always @(negedge clock) begin
        if (!reset && rd_resp_valid && rd_resp_ready) begin
            resp_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL resp_unexpected: got %h with no response outstanding", rd_resp_data);
            end else begin
                check_data("resp_data", rd_resp_data, exp_q.pop_front());
            end
        end
        if (!reset && rd_req_valid && rd_req_ready) exp_q.push_back(exp_rd_data);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_req_valid = 1'b0;
        rd_req_addr = '0;
        rd_resp_ready = 1'b0;
        exp_rd_data = '0;
        for (int i = 0; i < 6; i++) t4_d[i] = {16'hC0DE, 64'(i)};

        #3;
        check_bit("rst_ceb", sram_CEB, 1'b1);
        check_bit("rst_web", sram_WEB, 1'b1);
        check_bit("rst_wr_ready", wr_ready, 1'b0);
        check_bit("rst_rd_req_ready", rd_req_ready, 1'b0);
        check_bit("rst_resp_valid", rd_resp_valid, 1'b0);
        check_data("rst_resp_data", rd_resp_data, '0);
        check_data("rst_sram_d", sram_D, '0);
        check_data("rst_sram_a", {{(DW-AW){1'b0}}, sram_A}, '0);
        @(posedge clock);
        step();
        reset = 1'b0;

        // Write then read back one word.
        wr_valid = 1'b1;
        wr_addr = 6'd5;
        wr_data = 80'h0000_1111_2222_3333_4444;
        @(negedge clock);
        check_bit("t1_wr_ready", wr_ready, 1'b1);
        check_bit("t1_wr_ceb", sram_CEB, 1'b0);
        check_bit("t1_wr_web", sram_WEB, 1'b0);
        step();
        wr_valid = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr = 6'd5;
        rd_resp_ready = 1'b1;
        exp_rd_data = 80'h0000_1111_2222_3333_4444;
        resp_cycles.delete();
        @(negedge clock);
        check_bit("t1_rd_ready", rd_req_ready, 1'b1);
        check_bit("t1_rd_ceb", sram_CEB, 1'b0);
        check_bit("t1_rd_web", sram_WEB, 1'b1);
        grant_cyc = cyc;
        step();
        rd_req_valid = 1'b0;
        repeat (3) step();
        check_int("t1_resp_count", resp_cycles.size(), 1);
        if (resp_cycles.size() == 1) check_int("t1_latency", resp_cycles[0] - grant_cyc, 2);

        // Preload addr i with i*3.
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1;
            wr_addr = AW'(i);
            wr_data = DW'(i * 3);
            @(negedge clock);
            check_bit("pre_wr_ready", wr_ready, 1'b1);
            step();
        end
        wr_valid = 1'b0;

        // Back-to-back reads with a ready consumer.
        resp_cycles.delete();
        rd_resp_ready = 1'b1;
        rd_req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rd_req_addr = AW'(i);
            exp_rd_data = DW'(i * 3);
            @(negedge clock);
            check_bit("t2_rd_ready", rd_req_ready, 1'b1);
            if (i == 0) grant_cyc = cyc;
            step();
        end
        rd_req_valid = 1'b0;
        repeat (4) step();
        check_int("t2_resp_count", resp_cycles.size(), 20);
        if (resp_cycles.size() == 20) begin
            check_int("t2_first_latency", resp_cycles[0] - grant_cyc, 2);
            check_int("t2_span", resp_cycles[19] - resp_cycles[0], 19);
        end

        // Same reads against a stalled consumer.
        rd_resp_ready = 1'b0;
        rd_req_valid = 1'b1;
        idx = 0;
        repeat (5) begin
            rd_req_addr = AW'(idx);
            exp_rd_data = DW'(idx * 3);
            @(negedge clock);
            if (rd_req_ready) idx++;
            step();
        end
        check_int("t3_accepted", idx, 2);
        rd_req_addr = AW'(idx);
        exp_rd_data = DW'(idx * 3);
        @(negedge clock);
        check_bit("t3_rd_blocked", rd_req_ready, 1'b0);
        check_bit("t3_resp_valid", rd_resp_valid, 1'b1);
        check_data("t3_head", rd_resp_data, 80'd0);
        step();
        rd_resp_ready = 1'b1;
        @(negedge clock);
        check_bit("t3_resume_same_cycle", rd_req_ready, 1'b1);
        if (rd_req_ready) idx++;
        step();
        for (int k = 0; k < 100 && idx < 20; k++) begin
            rd_req_addr = AW'(idx);
            exp_rd_data = DW'(idx * 3);
            @(negedge clock);
            if (rd_req_ready) idx++;
            step();
        end
        check_int("t3_all_issued", idx, 20);
        rd_req_valid = 1'b0;
        repeat (4) step();
        check_int("t3_drained", exp_q.size(), 0);

        // Simultaneous write and read to addr 7: grants alternate starting with write.
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_addr = 6'd7;
            wr_data = t4_d[i];
            rd_req_valid = 1'b1;
            rd_req_addr = 6'd7;
            exp_rd_data = (i % 2 == 1) ? t4_d[i-1] : '0;
            @(negedge clock);
            check_bit("t4_wr_grant", wr_ready, (i % 2) == 0);
            check_bit("t4_rd_grant", rd_req_ready, (i % 2) == 1);
            step();
        end
        wr_valid = 1'b0;
        rd_req_valid = 1'b0;
        repeat (4) step();
        check_int("t4_drained", exp_q.size(), 0);

        // Reset with one response queued and one read in flight.
        rd_resp_ready = 1'b0;
        rd_req_valid = 1'b1;
        rd_req_addr = 6'd1;
        exp_rd_data = 80'd3;
        step();
        rd_req_addr = 6'd2;
        exp_rd_data = 80'd6;
        step();
        rd_req_valid = 1'b0;
        check_bit("t5_pre_valid", rd_resp_valid, 1'b1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_bit("t5_rst_valid", rd_resp_valid, 1'b0);
        check_data("t5_rst_data", rd_resp_data, '0);
        check_bit("t5_rst_ceb", sram_CEB, 1'b1);
        check_bit("t5_rst_web", sram_WEB, 1'b1);
        step();
        reset = 1'b0;
        rd_resp_ready = 1'b1;
        resp_cycles.delete();
        repeat (4) begin
            @(negedge clock);
            check_bit("t5_no_resp", rd_resp_valid, 1'b0);
        end
        step();
        check_int("t5_no_resp_count", resp_cycles.size(), 0);
        rd_req_valid = 1'b1;
        rd_req_addr = 6'd3;
        exp_rd_data = 80'd9;
        @(negedge clock);
        check_bit("t5_rd_ready", rd_req_ready, 1'b1);
        grant_cyc = cyc;
        step();
        rd_req_valid = 1'b0;
        repeat (3) step();
        check_int("t5_resp_count", resp_cycles.size(), 1);
        if (resp_cycles.size() == 1) check_int("t5_latency", resp_cycles[0] - grant_cyc, 2);

        // Idle cycles with garbage Q, empty then holding one entry.
        rd_resp_ready = 1'b0;
        repeat (3) begin
            @(negedge clock);
            check_bit("t6_idle_ceb", sram_CEB, 1'b1);
            check_bit("t6_idle_empty", rd_resp_valid, 1'b0);
        end
        step();
        rd_req_valid = 1'b1;
        rd_req_addr = 6'd10;
        exp_rd_data = 80'd30;
        step();
        rd_req_valid = 1'b0;
        repeat (2) step();
        repeat (5) begin
            @(negedge clock);
            check_bit("t6_hold_ceb", sram_CEB, 1'b1);
            check_bit("t6_hold_valid", rd_resp_valid, 1'b1);
            check_data("t6_hold_data", rd_resp_data, 80'd30);
        end
        step();
        rd_resp_ready = 1'b1;
        step();
        rd_resp_ready = 1'b0;
        step();
        check_bit("t6_empty_after", rd_resp_valid, 1'b0);
        check_int("end_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
